div_unit: RTL

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. Execute passes operands, signedness and a start request. The divider iterates one quotient bit per cycle, then returns a 64-bit {remainder, quotient} word with a ready flag. Execute holds the pipeline stalled while start is asserted and ready is low, then writes the result into HI/LO (HI = remainder, LO = quotient).

---
 rtl/div_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU), result = {remainder, quotient}.
// Optional early exit for |dividend| < |divisor| when DIV_EARLY_OUT_EN is defined.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;     // {rem[31:0], quo[31:0]}
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] abs1, abs2;
    logic [64:0] shifted;
    logic [32:0] diff;
    logic [31:0] quo_fix, rem_fix;

    assign abs1 = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
    assign abs2 = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

    // Remainder stays below the divisor, so bit 64 of the shifted word is only
    // ever set when the subtraction succeeds; 32 bits of stored remainder suffice.
    assign shifted = {work_q, 1'b0};
    assign diff    = shifted[64:32] - {1'b0, divisor_q};

    assign quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~work_q[31:0] + 32'd1)
                                                        : work_q[31:0];
    assign rem_fix = (signed_q && sign1_q) ? (~work_q[63:32] + 32'd1) : work_q[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        ready_d   = ready_q;

        if (annul) begin
            state_d  = StFree;
            result_d = 64'h0;
            ready_d  = 1'b0;
        end else begin
            case (state_q)
                StFree: begin
                    if (start) begin
                        if (opdata2 == 32'h0) begin
                            state_d = StByZero;
`ifdef DIV_EARLY_OUT_EN
                        end else if (abs1 < abs2) begin
                            state_d  = StEnd;
                            result_d = {opdata1, 32'h0};
                            ready_d  = 1'b1;
`endif
                        end else begin
                            work_d    = {32'h0, abs1};
                            divisor_d = abs2;
                            signed_d  = signed_div;
                            sign1_d   = opdata1[31];
                            sign2_d   = opdata2[31];
                            cnt_d     = 6'd0;
                            state_d   = StOn;
                        end
                    end
                end
                StByZero: begin
                    state_d  = StEnd;
                    result_d = 64'h0;
                    ready_d  = 1'b1;
                end
                StOn: begin
                    if (cnt_q == 6'd32) begin
                        state_d  = StEnd;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end else begin
                        work_d = diff[32] ? shifted[63:0] : {diff[31:0], shifted[31:1], 1'b1};
                        cnt_d  = cnt_q + 6'd1;
                    end
                end
                StEnd: begin
                    if (!start) begin
                        state_d  = StFree;
                        result_d = 64'h0;
                        ready_d  = 1'b0;
                    end
                end
                default: state_d = StFree;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFree;
            cnt_q     <= 6'd0;
            work_q    <= 64'h0;
            divisor_q <= 32'h0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule
